mouse_packet_master: RTL and testbench

MOUSE_PACKET_MASTER -- requirements
Module: mouse_packet_master

---
 rtl/mouse_packet_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mouse_packet_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_packet_master.sv
// PS/2 mouse host controller: brings the mouse up and collects packets.
// Macro MOUSE_WHEEL_EN adds the wheel knock sequence and 4-byte packets.
// Ports:
//   CLK, RESET          clock and async active-high reset
//   SEND_BYTE, BYTE_TO_SEND, BYTE_SENT
//                       one-cycle transmit strobe, command byte, done strobe
//   READ_ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
//                       receiver enable, received byte, error code, strobe
//   MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ
//                       last complete packet
//   WHEEL_MODE          4-byte packets active
//   INIT_DONE           streaming active
//   INIT_FAIL           init abandoned
//   SEND_INTERRUPT      one-cycle new-packet pulse
module mouse_packet_master #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       WHEEL_MODE,
  output logic       INIT_DONE,
  output logic       INIT_FAIL,
  output logic       SEND_INTERRUPT
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RET_LAST = RW'(MAX_RETRIES - 1);

  localparam logic [1:0] K_SEND = 2'd0;
  localparam logic [1:0] K_READ = 2'd1;
  localparam logic [1:0] K_RDID = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef enum logic [2:0] {
    S_STEP,
    S_WSENT,
    S_READ,
    S_STREAM,
    S_FAIL
  } state_e;

  // Init program: {kind, byte}. Reads compare against byte.
  function automatic logic [9:0] step_of(input logic [4:0] i);
    logic [9:0] r;
    r = {K_DONE, 8'h00};
    case (i)
      5'd0:  r = {K_SEND, 8'hFF};
      5'd1:  r = {K_READ, 8'hFA};
      5'd2:  r = {K_READ, 8'hAA};
      5'd3:  r = {K_READ, 8'h00};
`ifdef MOUSE_WHEEL_EN
      5'd4:  r = {K_SEND, 8'hF3};
      5'd5:  r = {K_READ, 8'hFA};
      5'd6:  r = {K_SEND, 8'hC8};
      5'd7:  r = {K_READ, 8'hFA};
      5'd8:  r = {K_SEND, 8'hF3};
      5'd9:  r = {K_READ, 8'hFA};
      5'd10: r = {K_SEND, 8'h64};
      5'd11: r = {K_READ, 8'hFA};
      5'd12: r = {K_SEND, 8'hF3};
      5'd13: r = {K_READ, 8'hFA};
      5'd14: r = {K_SEND, 8'h50};
      5'd15: r = {K_READ, 8'hFA};
      5'd16: r = {K_SEND, 8'hF2};
      5'd17: r = {K_READ, 8'hFA};
      5'd18: r = {K_RDID, 8'h00};
      5'd19: r = {K_SEND, 8'hF4};
      5'd20: r = {K_READ, 8'hFA};
`else
      5'd4:  r = {K_SEND, 8'hF4};
      5'd5:  r = {K_READ, 8'hFA};
`endif
      default: r = {K_DONE, 8'h00};
    endcase
    return r;
  endfunction

  state_e        state_q;
  logic [4:0]    step_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;
  logic [1:0]    idx_q;
  logic [7:0]    sh0_q, sh1_q, sh2_q;
  logic          send_q, read_en_q;
  logic [7:0]    tx_q;
  logic [7:0]    st_q, dx_q, dy_q, dz_q;
  logic          wheel_q, done_q, fail_q, irq_q;

  logic [9:0] cur;
  logic [1:0] cur_kind;
  logic [7:0] cur_val;
  logic       tmo_hit;
  logic       adv, abt, id_wheel;
  logic [1:0] last_idx;

  assign cur      = step_of(step_q);
  assign cur_kind = cur[9:8];
  assign cur_val  = cur[7:0];
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign last_idx = wheel_q ? 2'd3 : 2'd2;

  // Step outcome; a strobe wins over a coincident timeout.
  always_comb begin
    adv      = 1'b0;
    abt      = 1'b0;
    id_wheel = wheel_q;
    unique case (state_q)
      S_WSENT: begin
        if (BYTE_SENT) adv = 1'b1;
        else if (tmo_hit) abt = 1'b1;
      end
      S_READ: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            abt = 1'b1;
          end else if (cur_kind == K_RDID) begin
`ifdef MOUSE_WHEEL_EN
            if (BYTE_READ == 8'h03) begin
              adv      = 1'b1;
              id_wheel = 1'b1;
            end else if (BYTE_READ == 8'h00) begin
              adv      = 1'b1;
              id_wheel = 1'b0;
            end else begin
              abt = 1'b1;
            end
`else
            abt = 1'b1;
`endif
          end else if (BYTE_READ == cur_val) begin
            adv = 1'b1;
          end else begin
            abt = 1'b1;
          end
        end else if (tmo_hit) begin
          abt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_STEP;
      step_q    <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      send_q    <= 1'b0;
      read_en_q <= 1'b0;
      tx_q      <= '0;
      st_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      wheel_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      send_q <= 1'b0;
      irq_q  <= 1'b0;
      unique case (state_q)
        S_STEP: begin
          tmo_q <= '0;
          unique case (cur_kind)
            K_SEND: begin
              send_q    <= 1'b1;
              tx_q      <= cur_val;
              read_en_q <= 1'b0;
              state_q   <= S_WSENT;
            end
            K_DONE: begin
              done_q    <= 1'b1;
              read_en_q <= 1'b1;
              idx_q     <= '0;
              state_q   <= S_STREAM;
            end
            default: begin
              read_en_q <= 1'b1;
              state_q   <= S_READ;
            end
          endcase
        end
        S_WSENT, S_READ: begin
          if (adv) begin
            step_q  <= step_q + 5'd1;
            tmo_q   <= '0;
            wheel_q <= id_wheel;
            state_q <= S_STEP;
          end else if (abt) begin
            step_q    <= '0;
            tmo_q     <= '0;
            wheel_q   <= 1'b0;
            read_en_q <= 1'b0;
            if (retry_q == RET_LAST) begin
              fail_q  <= 1'b1;
              state_q <= S_FAIL;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_STEP;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (BYTE_READY) begin
            tmo_q <= '0;
            if (BYTE_ERROR_CODE != 2'b00) begin
              idx_q <= '0;
            end else if (idx_q == 2'd0) begin
              // Byte 0 always has bit 3 set; anything else is resync noise.
              if (BYTE_READ[3]) begin
                sh0_q <= BYTE_READ;
                idx_q <= 2'd1;
              end
            end else if (idx_q == last_idx) begin
              st_q  <= sh0_q;
              dx_q  <= sh1_q;
              dy_q  <= wheel_q ? sh2_q : BYTE_READ;
              dz_q  <= wheel_q ? BYTE_READ : 8'h00;
              irq_q <= 1'b1;
              idx_q <= '0;
            end else begin
              if (idx_q == 2'd1) sh1_q <= BYTE_READ;
              else sh2_q <= BYTE_READ;
              idx_q <= idx_q + 2'd1;
            end
          end else if (idx_q != 2'd0) begin
            if (tmo_hit) idx_q <= '0;
            else tmo_q <= tmo_q + 1'b1;
          end
        end
        S_FAIL: begin
          read_en_q <= 1'b0;
        end
        default: state_q <= S_STEP;
      endcase
    end
  end

  assign SEND_BYTE      = send_q;
  assign BYTE_TO_SEND   = tx_q;
  assign READ_ENABLE    = read_en_q;
  assign MOUSE_STATUS   = st_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign MOUSE_DZ       = dz_q;
  assign WHEEL_MODE     = wheel_q;
  assign INIT_DONE      = done_q;
  assign INIT_FAIL      = fail_q;
  assign SEND_INTERRUPT = irq_q;

endmodule

// File: tb/tb_mouse_packet_master.sv
// Bench for mouse_packet_master: mouse model plus directed packets.
// Covers init, retry, failure, resync, stream timeout and reset.
module tb_mouse_packet_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_byte;
  logic [7:0] tx;
  logic       byte_sent = 1'b0;
  logic       rd_en;
  logic [7:0] rx;
  logic [1:0] err = 2'b00;
  logic       rdy;
  logic [7:0] st, dx, dy, dz;
  logic       wm, done, fail, irq;

  logic [7:0] m_rx = 8'h00;
  logic       m_rdy = 1'b0;
  logic [7:0] s_rx = 8'h00;
  logic       s_rdy = 1'b0;

  assign rx  = m_rdy ? m_rx : s_rx;
  assign rdy = m_rdy | s_rdy;

  int n_tot = 0;
  int n_bad = 0;

  int ff_cnt = 0;
  int send_cnt = 0;
  int irq_cnt = 0;
  int bad_req = 0;
  int bad_used = 0;
  bit ack_en = 1'b1;
  bit resp_en = 1'b1;

`ifdef MOUSE_WHEEL_EN
  localparam logic [7:0] P0 = 8'h09;
  localparam logic [7:0] P1 = 8'h01;
  localparam logic [7:0] P2 = 8'h02;
  localparam logic [7:0] P3 = 8'hFF;
  localparam logic [7:0] EXP_DZ = 8'hFF;
  localparam int EXP_WM = 1;
  localparam int INIT_SENDS = 9;
`else
  localparam logic [7:0] P0 = 8'h08;
  localparam logic [7:0] P1 = 8'h05;
  localparam logic [7:0] P2 = 8'hFB;
  localparam logic [7:0] P3 = 8'h00;
  localparam logic [7:0] EXP_DZ = 8'h00;
  localparam int EXP_WM = 0;
  localparam int INIT_SENDS = 2;
`endif

  mouse_packet_master #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES(3)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .SEND_BYTE(send_byte),
    .BYTE_TO_SEND(tx),
    .BYTE_SENT(byte_sent),
    .READ_ENABLE(rd_en),
    .BYTE_READ(rx),
    .BYTE_ERROR_CODE(err),
    .BYTE_READY(rdy),
    .MOUSE_STATUS(st),
    .MOUSE_DX(dx),
    .MOUSE_DY(dy),
    .MOUSE_DZ(dz),
    .WHEEL_MODE(wm),
    .INIT_DONE(done),
    .INIT_FAIL(fail),
    .SEND_INTERRUPT(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq) irq_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reply(input logic [7:0] b);
    int k;
    k = 0;
    while (!rd_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (rd_en) begin
      repeat (2) @(negedge clk);
      m_rx  = b;
      m_rdy = 1'b1;
      @(negedge clk);
      m_rdy = 1'b0;
    end
  endtask

  // Mouse model: acks every command, answers per PS/2 protocol.
  initial begin
    logic [7:0] cmd;
    forever begin
      @(negedge clk);
      if (send_byte && !rst) begin
        cmd = tx;
        send_cnt++;
        if (cmd == 8'hFF) ff_cnt++;
        if (ack_en) begin
          repeat (2) @(negedge clk);
          byte_sent = 1'b1;
          @(negedge clk);
          byte_sent = 1'b0;
          if (resp_en) begin
            if (cmd == 8'hFF) begin
              if (bad_used != bad_req) begin
                bad_used++;
                reply(8'hAA);
              end else begin
                reply(8'hFA);
                reply(8'hAA);
                reply(8'h00);
              end
            end else if (cmd == 8'hF2) begin
              reply(8'hFA);
              reply(8'h03);
            end else begin
              reply(8'hFA);
            end
          end
        end
      end
    end
  end

  task automatic rbyte(input logic [7:0] b, input logic [1:0] e);
    @(negedge clk);
    s_rx  = b;
    err   = e;
    s_rdy = 1'b1;
    @(negedge clk);
    s_rdy = 1'b0;
    err   = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d);
    rbyte(a, 2'b00);
    rbyte(b, 2'b00);
    rbyte(c, 2'b00);
`ifdef MOUSE_WHEEL_EN
    rbyte(d, 2'b00);
`else
    if (d != 8'h00) $display("note: byte %0h unused in 3-byte mode", d);
`endif
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && !done; i++) @(negedge clk);
  endtask

  task automatic wait_fail(input int max);
    for (int i = 0; i < max && !fail; i++) @(negedge clk);
  endtask

  initial begin
    int ff0, snd0, irq0;

    repeat (3) @(negedge clk);
    check("rst_send", send_byte, 0);
    check("rst_rden", rd_en, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_stat", st, 0);
    check("rst_wm", wm, 0);

    // Nominal init
    ff0 = ff_cnt;
    rst = 1'b0;
    wait_done(3000);
    check("init_done", done, 1);
    check("init_fail", fail, 0);
    check("init_ff", ff_cnt - ff0, 1);
    check("init_wm", wm, EXP_WM);

    // Nominal packet
    irq0 = irq_cnt;
`ifdef MOUSE_WHEEL_EN
    rbyte(P0, 2'b00);
    rbyte(P1, 2'b00);
    rbyte(P2, 2'b00);
    check("wh_no_irq3", irq_cnt - irq0, 0);
    rbyte(P3, 2'b00);
`else
    pkt(P0, P1, P2, P3);
`endif
    check("nom_irq", irq_cnt - irq0, 1);
    check("nom_stat", st, P0);
    check("nom_dx", dx, P1);
    check("nom_dy", dy, P2);
    check("nom_dz", dz, EXP_DZ);

    // Resync and error byte
    irq0 = irq_cnt;
    rbyte(8'h00, 2'b00);
    rbyte(8'h08, 2'b00);
    rbyte(8'h11, 2'b01);
    repeat (5) @(negedge clk);
    check("err_irq", irq_cnt - irq0, 0);
    check("err_hold_dx", dx, P1);
    pkt(8'h08, 8'h00, 8'h00, 8'h00);
    check("clean_irq", irq_cnt - irq0, 1);
    check("clean_stat", st, 8'h08);
    check("clean_dx", dx, 8'h00);
    check("clean_dy", dy, 8'h00);

    // Inter-byte timeout discards partial packet
    irq0 = irq_cnt;
    rbyte(8'h08, 2'b00);
    repeat (150) @(negedge clk);
    rbyte(8'h01, 2'b00);
    rbyte(8'h02, 2'b00);
    pkt(8'h08, 8'h03, 8'h04, 8'h05);
    check("tmo_irq", irq_cnt - irq0, 1);
    check("tmo_dx", dx, 8'h03);
    check("tmo_dy", dy, 8'h04);

    // Reset mid-packet, then retry on a bad first reply
    rbyte(8'h08, 2'b00);
    rbyte(8'h07, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_stat", st, 0);
    check("mrst_dx", dx, 0);
    check("mrst_done", done, 0);
    check("mrst_rden", rd_en, 0);
    bad_req++;
    ff0  = ff_cnt;
    snd0 = send_cnt;
    @(negedge clk);
    rst = 1'b0;
    wait_done(3000);
    check("retry_done", done, 1);
    check("retry_fail", fail, 0);
    check("retry_ff", ff_cnt - ff0, 2);
    check("retry_sends", send_cnt - snd0, INIT_SENDS + 1);

    // Silent mouse: transmitter acks, no replies
    rst = 1'b1;
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    ff0  = ff_cnt;
    snd0 = send_cnt;
    rst = 1'b0;
    wait_fail(3000);
    check("sil_fail", fail, 1);
    check("sil_done", done, 0);
    check("sil_ff", ff_cnt - ff0, 3);
    check("sil_rden", rd_en, 0);
    repeat (300) @(negedge clk);
    check("sil_nosend", send_cnt - snd0, 3);

    // Transmitter never acks
    rst = 1'b1;
    ack_en = 1'b0;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    ff0 = ff_cnt;
    rst = 1'b0;
    wait_fail(3000);
    check("nack_fail", fail, 1);
    repeat (300) @(negedge clk);
    check("nack_ff", ff_cnt - ff0, 3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
